age_tracking_entry_bank: RTL and testbench

- Entry bank that produces the per-entry condition bits and packed age values for the downstream oldest-ready selector.
- It consumes the pointer the selector returns.
- Tracks valid entries, ages them with saturating counters, allocates the lowest free slot, and frees the entry the consumer issues.
- Forms the writer/owner side of the select interface in issue queues and replacement logic.

---
 rtl/age_tracking_entry_bank.sv | 161 ++++++++++++++++
 tb/tb_age_tracking_entry_bank.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/age_tracking_entry_bank.sv
// ---------------------------------------------------------------------------
// age_tracking_entry_bank
//
// Owner side of an oldest-ready select interface. The bank tracks which
// entries are valid and gives each valid entry a saturating age counter. It
// allocates the lowest free slot and frees the slot that the downstream
// consumer issues. It presents per-entry condition bits and packed ages to
// the selector.
//
// Ports:
//   clk_in          clock, all state updates on the rising edge
//   reset_in        synchronous active-high reset
//   age_tick_in     ages every valid, non-issued entry by one
//   alloc_valid_in  allocation request
//   alloc_ready_out bank not full
//   alloc_ptr_out   lowest free entry (0 when full)
//   ready_mask_in   per-entry external readiness
//   issue_valid_in  consumer frees issue_ptr_in this cycle
//   issue_ptr_in    pointer returned by the selector
//   condition_out   valid & ready_mask_in
//   elements_out    packed ages, entry i at [(i+1)*W-1 : i*W]
//   any_ready_out   OR of condition_out
//   occupancy_out   number of valid entries
//   full_out        occupancy == NUM_ELEMENTS
//   empty_out       occupancy == 0
//   issue_error_out one-cycle pulse after an illegal issue
// ---------------------------------------------------------------------------
module age_tracking_entry_bank #(
    parameter int NUM_ELEMENTS                 = 8,
    parameter int ELEMENT_PTR_SIZE_IN_BITS     = 3,
    parameter int SINGLE_ELEMENT_WIDTH_IN_BITS = 3
) (
    input  logic                                                  clk_in,
    input  logic                                                  reset_in,
    input  logic                                                  age_tick_in,
    input  logic                                                  alloc_valid_in,
    output logic                                                  alloc_ready_out,
    output logic [ELEMENT_PTR_SIZE_IN_BITS-1:0]                   alloc_ptr_out,
    input  logic [NUM_ELEMENTS-1:0]                               ready_mask_in,
    input  logic                                                  issue_valid_in,
    input  logic [ELEMENT_PTR_SIZE_IN_BITS-1:0]                   issue_ptr_in,
    output logic [NUM_ELEMENTS-1:0]                               condition_out,
    output logic [SINGLE_ELEMENT_WIDTH_IN_BITS*NUM_ELEMENTS-1:0]  elements_out,
    output logic                                                  any_ready_out,
    output logic [ELEMENT_PTR_SIZE_IN_BITS:0]                     occupancy_out,
    output logic                                                  full_out,
    output logic                                                  empty_out,
    output logic                                                  issue_error_out
);

    localparam int N = NUM_ELEMENTS;
    localparam int P = ELEMENT_PTR_SIZE_IN_BITS;
    localparam int W = SINGLE_ELEMENT_WIDTH_IN_BITS;

    localparam logic [P:0]   FULL_COUNT = (P+1)'(N);
    localparam logic [W-1:0] AGE_MAX    = {W{1'b1}};
    // New entries start at 1 so that they always rank above the zero the
    // selector substitutes for entries without their condition bit.
    localparam logic [W-1:0] AGE_ONE    = W'(1);

    // Saturating increment of an age counter.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] age);
        logic [W-1:0] result;
        if (age == AGE_MAX) begin
            result = age;
        end else begin
            result = age + W'(1);
        end
        return result;
    endfunction

    logic [N-1:0]   valid_r;
    logic [W-1:0]   age_r [N];
    logic [P:0]     occ_r;
    logic           issue_error_r;

    logic [N-1:0]   valid_nxt_s;
    logic [W-1:0]   age_nxt_s [N];
    logic [P:0]     occ_nxt_s;
    logic [P-1:0]   alloc_ptr_s;
    logic           full_s;
    logic           alloc_fire_s;
    logic           issue_legal_s;
    logic [N-1:0]   condition_s;

    assign full_s        = (occ_r == FULL_COUNT);
    // No bypass: a same-cycle issue does not make room for an allocation.
    assign alloc_fire_s  = alloc_valid_in & ~full_s;
    assign issue_legal_s = issue_valid_in & (int'(issue_ptr_in) < N) & valid_r[issue_ptr_in];
    assign condition_s   = valid_r & ready_mask_in;

    // Lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        alloc_ptr_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            alloc_ptr_s = valid_r[i] ? alloc_ptr_s : P'(i);
        end
    end

    // Per-entry next valid/age. Alloc and legal issue never hit the same
    // slot because the alloc slot is free and the issued slot is valid.
    always_comb begin
        valid_nxt_s = valid_r;
        for (int i = 0; i < N; i++) begin
            age_nxt_s[i] = age_r[i];
            if (alloc_fire_s && (alloc_ptr_s == P'(i))) begin
                valid_nxt_s[i] = 1'b1;
                age_nxt_s[i]   = AGE_ONE;
            end else if (issue_legal_s && (issue_ptr_in == P'(i))) begin
                valid_nxt_s[i] = 1'b0;
                age_nxt_s[i]   = '0;
            end else if (age_tick_in && valid_r[i]) begin
                age_nxt_s[i]   = sat_inc(age_r[i]);
            end else begin
                age_nxt_s[i]   = age_r[i];
            end
        end
    end

    // Occupancy moves only when exactly one of alloc / legal issue happens.
    always_comb begin
        case ({alloc_fire_s, issue_legal_s})
            2'b10:   occ_nxt_s = occ_r + (P+1)'(1);
            2'b01:   occ_nxt_s = occ_r - (P+1)'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // State registers with synchronous reset overriding every request.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            valid_r       <= '0;
            age_r         <= '{default: '0};
            occ_r         <= '0;
            issue_error_r <= 1'b0;
        end else begin
            valid_r       <= valid_nxt_s;
            age_r         <= age_nxt_s;
            occ_r         <= occ_nxt_s;
            issue_error_r <= issue_valid_in & ~issue_legal_s;
        end
    end

    // Pack the ages for the selector.
    always_comb begin
        elements_out = '0;
        for (int i = 0; i < N; i++) begin
            elements_out[i*W +: W] = age_r[i];
        end
    end

    assign alloc_ready_out = ~full_s;
    assign alloc_ptr_out   = alloc_ptr_s;
    assign condition_out   = condition_s;
    assign any_ready_out   = |condition_s;
    assign occupancy_out   = occ_r;
    assign full_out        = full_s;
    assign empty_out       = (occ_r == (P+1)'(0));
    assign issue_error_out = issue_error_r;

endmodule

// File: tb/tb_age_tracking_entry_bank.sv
// ---------------------------------------------------------------------------
// Bench for age_tracking_entry_bank. A behavioural model of the entry bank
// (arrays of valid flags and integer ages) is checked against the DUT on every
// falling edge. Directed steps add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_age_tracking_entry_bank;

    localparam int N = 8;
    localparam int P = 3;
    localparam int W = 3;
    localparam int AGE_SAT = 7;

    logic           clk = 1'b0;
    logic           reset_in = 1'b1;
    logic           age_tick_in = 1'b0;
    logic           alloc_valid_in = 1'b0;
    logic           alloc_ready_out;
    logic [P-1:0]   alloc_ptr_out;
    logic [N-1:0]   ready_mask_in = '0;
    logic           issue_valid_in = 1'b0;
    logic [P-1:0]   issue_ptr_in = '0;
    logic [N-1:0]   condition_out;
    logic [W*N-1:0] elements_out;
    logic           any_ready_out;
    logic [P:0]     occupancy_out;
    logic           full_out;
    logic           empty_out;
    logic           issue_error_out;

    age_tracking_entry_bank #(
        .NUM_ELEMENTS(N),
        .ELEMENT_PTR_SIZE_IN_BITS(P),
        .SINGLE_ELEMENT_WIDTH_IN_BITS(W)
    ) dut (
        .clk_in(clk),
        .reset_in(reset_in),
        .age_tick_in(age_tick_in),
        .alloc_valid_in(alloc_valid_in),
        .alloc_ready_out(alloc_ready_out),
        .alloc_ptr_out(alloc_ptr_out),
        .ready_mask_in(ready_mask_in),
        .issue_valid_in(issue_valid_in),
        .issue_ptr_in(issue_ptr_in),
        .condition_out(condition_out),
        .elements_out(elements_out),
        .any_ready_out(any_ready_out),
        .occupancy_out(occupancy_out),
        .full_out(full_out),
        .empty_out(empty_out),
        .issue_error_out(issue_error_out)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    // Behavioural model state.
    bit  m_valid [N];
    int  m_age   [N];
    bit  m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_valid[i] ? 1 : 0;
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return 0;
    endfunction

    // Apply one clock edge's worth of rules to the model.
    task automatic model_step();
        bit fire, legal;
        int slot, ip;
        if (reset_in) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_age[i]   = 0;
            end
            m_err = 1'b0;
        end else begin
            slot  = m_lowest_free();
            fire  = alloc_valid_in && (m_count() < N);
            ip    = int'(issue_ptr_in);
            legal = issue_valid_in && (ip < N) && m_valid[ip];
            for (int i = 0; i < N; i++) begin
                if (age_tick_in && m_valid[i] && !(legal && i == ip))
                    m_age[i] = (m_age[i] + 1 > AGE_SAT) ? AGE_SAT : m_age[i] + 1;
            end
            if (legal) begin
                m_valid[ip] = 1'b0;
                m_age[ip]   = 0;
            end
            if (fire) begin
                m_valid[slot] = 1'b1;
                m_age[slot]   = 1;
            end
            m_err = issue_valid_in && !legal;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #2;
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0]   e_cond;
            logic [W*N-1:0] e_elem;
            int             cnt;
            cnt = m_count();
            for (int i = 0; i < N; i++) begin
                e_cond[i]       = m_valid[i] & ready_mask_in[i];
                e_elem[i*W +: W] = W'(m_age[i]);
            end
            chk("occupancy", 64'(occupancy_out), 64'(cnt));
            chk("full", 64'(full_out), 64'(cnt == N));
            chk("empty", 64'(empty_out), 64'(cnt == 0));
            chk("alloc_ready", 64'(alloc_ready_out), 64'(cnt != N));
            chk("alloc_ptr", 64'(alloc_ptr_out), 64'(m_lowest_free()));
            chk("condition", 64'(condition_out), 64'(e_cond));
            chk("any_ready", 64'(any_ready_out), 64'(|e_cond));
            chk("elements", 64'(elements_out), 64'(e_elem));
            chk("issue_error", 64'(issue_error_out), 64'(m_err));
        end
    end

    int sat_exp [10] = '{2, 3, 4, 5, 6, 7, 7, 7, 7, 7};

    initial begin
        // Reset held two cycles with an allocation request pending.
        reset_in = 1'b1;
        alloc_valid_in = 1'b1;
        cycle();
        chk_en = 1'b1;
        cycle();
        reset_in = 1'b0;
        alloc_valid_in = 1'b0;
        chk("rst_occ", 64'(occupancy_out), 64'd0);
        chk("rst_empty", 64'(empty_out), 64'd1);
        chk("rst_ptr", 64'(alloc_ptr_out), 64'd0);
        chk("rst_ready", 64'(alloc_ready_out), 64'd1);
        chk("rst_elem", 64'(elements_out), 64'd0);

        // Fill all eight slots without ticking.
        for (int k = 0; k < N; k++) begin
            chk("fill_ptr", 64'(alloc_ptr_out), 64'(k));
            alloc_valid_in = 1'b1;
            cycle();
        end
        alloc_valid_in = 1'b0;
        chk("fill_full", 64'(full_out), 64'd1);
        chk("fill_ready", 64'(alloc_ready_out), 64'd0);
        chk("fill_ptr0", 64'(alloc_ptr_out), 64'd0);
        chk("fill_ages", 64'(elements_out), 64'o11111111);

        // Ninth request while full is ignored.
        alloc_valid_in = 1'b1;
        cycle();
        alloc_valid_in = 1'b0;
        chk("ninth_occ", 64'(occupancy_out), 64'd8);
        chk("ninth_ages", 64'(elements_out), 64'o11111111);

        // Alloc + issue while full: only the issue takes effect.
        alloc_valid_in = 1'b1;
        issue_valid_in = 1'b1;
        issue_ptr_in   = 3'd5;
        cycle();
        issue_valid_in = 1'b0;
        chk("simul_occ", 64'(occupancy_out), 64'd7);
        chk("simul_ptr", 64'(alloc_ptr_out), 64'd5);
        chk("simul_ages", 64'(elements_out), 64'o11011111);
        cycle();
        alloc_valid_in = 1'b0;
        chk("refill_full", 64'(full_out), 64'd1);
        chk("refill_ages", 64'(elements_out), 64'o11111111);

        // Free entry 3, then issue it again illegally.
        issue_valid_in = 1'b1;
        issue_ptr_in   = 3'd3;
        cycle();
        chk("legal_err", 64'(issue_error_out), 64'd0);
        cycle();
        issue_valid_in = 1'b0;
        chk("illegal_err", 64'(issue_error_out), 64'd1);
        chk("illegal_occ", 64'(occupancy_out), 64'd7);
        cycle();
        chk("err_pulse_end", 64'(issue_error_out), 64'd0);

        // Saturation of a single entry; alloc ignores the tick.
        reset_in = 1'b1;
        cycle();
        reset_in = 1'b0;
        alloc_valid_in = 1'b1;
        age_tick_in    = 1'b1;
        cycle();
        alloc_valid_in = 1'b0;
        chk("sat_start", 64'(elements_out[W-1:0]), 64'd1);
        for (int n = 0; n < 10; n++) begin
            ready_mask_in = (n % 2 == 0) ? 8'h01 : 8'h00;
            cycle();
            chk("sat_age", 64'(elements_out[W-1:0]), 64'(sat_exp[n]));
        end
        age_tick_in = 1'b0;

        // Random traffic with an oldest-ready selector closing the loop.
        reset_in = 1'b1;
        cycle();
        reset_in = 1'b0;
        for (int t = 0; t < 300; t++) begin
            int sel, best, mx;
            ready_mask_in  = N'($urandom);
            alloc_valid_in = 1'($urandom_range(0, 1));
            age_tick_in    = 1'($urandom_range(0, 1));
            #1;
            sel  = 0;
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (condition_out[i] && int'(elements_out[i*W +: W]) > best) begin
                    best = int'(elements_out[i*W +: W]);
                    sel  = i;
                end
            end
            issue_valid_in = any_ready_out;
            issue_ptr_in   = P'(sel);
            if (any_ready_out) begin
                mx = -1;
                for (int i = 0; i < N; i++)
                    if (m_valid[i] && ready_mask_in[i] && m_age[i] > mx) mx = m_age[i];
                chk("sel_is_oldest", 64'(m_valid[sel] && ready_mask_in[sel] && m_age[sel] == mx), 64'd1);
            end
            cycle();
        end
        issue_valid_in = 1'b0;
        alloc_valid_in = 1'b0;
        age_tick_in    = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
